// File: rtl/aud_player_tx.sv
// aud_player_tx: I2S-style serial audio transmitter, one-entry sample buffer, MSB-first on codec BCLK
// Ports:
//   i_clk      codec BCLK, all logic on rising edge
//   i_rst_n    asynchronous reset, active high (asserted = 1)
//   i_lrc      codec LR clock, synchronous to i_clk
//   i_en       play enable; low pauses after the current word
//   i_stop     one-cycle pulse: abort word and flush buffer
//   i_valid    i_data holds a sample
//   i_data     PCM sample, two's complement
//   o_ready    buffer can accept a sample
//   o_dacdat   registered serial data to the DAC
//   o_busy     a word is being shifted
//   o_underrun one-cycle pulse: active edge with i_en=1 and empty buffer
module aud_player_tx #(
    parameter int DATA_W  = 16,
    parameter bit CHANNEL = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_en,
    input  logic              i_stop,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_dacdat,
    output logic              o_busy,
    output logic              o_underrun
);
    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W);

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t            state;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] shift;
    logic              buf_valid;
    logic [CW-1:0]     cnt;
    logic              lrc_q;
    logic              act_edge;

    assign act_edge = (i_lrc != lrc_q) && (i_lrc == CHANNEL);
    assign o_ready  = !buf_valid;

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            state      <= IDLE;
            buf_data   <= '0;
            shift      <= '0;
            buf_valid  <= 1'b0;
            cnt        <= '0;
            lrc_q      <= 1'b0;
            o_dacdat   <= 1'b0;
            o_busy     <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            lrc_q      <= i_lrc;
            o_underrun <= 1'b0;
            if (i_stop) begin
                state     <= IDLE;
                buf_valid <= 1'b0;
                cnt       <= '0;
                o_dacdat  <= 1'b0;
                o_busy    <= 1'b0;
            end else begin
                // accept only when empty, so it can never coincide with a drain
                if (i_valid && o_ready) begin
                    buf_data  <= i_data;
                    buf_valid <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        o_dacdat <= 1'b0;
                        if (i_en) state <= WAIT;
                    end
                    WAIT: begin
                        if (!i_en) begin
                            state <= IDLE;
                        end else if (act_edge) begin
                            if (buf_valid) begin
                                // MSB goes out on the edge that detects the LRC transition
                                shift     <= buf_data << 1;
                                o_dacdat  <= buf_data[DATA_W-1];
                                buf_valid <= 1'b0;
                                cnt       <= CW'(1);
                                o_busy    <= 1'b1;
                                state     <= SEND;
                            end else begin
                                o_underrun <= 1'b1;
                            end
                        end
                    end
                    SEND: begin
                        if (cnt == LAST) begin
                            o_dacdat <= 1'b0;
                            o_busy   <= 1'b0;
                            cnt      <= '0;
                            state    <= i_en ? WAIT : IDLE;
                        end else begin
                            o_dacdat <= shift[DATA_W-1];
                            shift    <= shift << 1;
                            cnt      <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aud_player_tx.sv
// tb_aud_player_tx: directed, table-driven bench for the I2S transmitter (left and right channel builds)
module tb_aud_player_tx;
    logic        i_clk, i_rst_n, i_lrc, i_en, i_stop, i_valid;
    logic [15:0] i_data;
    logic        o_ready0, o_dacdat0, o_busy0, o_underrun0;
    logic        o_ready1, o_dacdat1, o_busy1, o_underrun1;

    aud_player_tx #(.DATA_W(16), .CHANNEL(1'b0)) dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lrc(i_lrc), .i_en(i_en), .i_stop(i_stop),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready0), .o_dacdat(o_dacdat0),
        .o_busy(o_busy0), .o_underrun(o_underrun0));

    aud_player_tx #(.DATA_W(16), .CHANNEL(1'b1)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lrc(i_lrc), .i_en(i_en), .i_stop(i_stop),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready1), .o_dacdat(o_dacdat1),
        .o_busy(o_busy1), .o_underrun(o_underrun1));

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic        load;
        logic [15:0] smp;
        logic [15:0] exp_w;
        logic        exp_ur;
    } vec_t;

    vec_t        tbl [5];
    int          checks = 0;
    int          failures = 0;
    logic [39:0] cap_d0, cap_d1;
    int          b0, b1, u0, u1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // serial image of one half-frame: slot j holds what o_dacdat shows after the j-th edge
    function automatic logic [39:0] ev(input logic [15:0] w, input int n);
        logic [39:0] v = '0;
        for (int j = 1; j <= n; j++) v[j] = w[16-j];
        return v;
    endfunction

    task automatic do_load(input logic [15:0] v, input bit ch1);
        int n = 0;
        while (!(ch1 ? o_ready1 : o_ready0) && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (n == 100) chk("load_timeout", 64'd1, 64'd0);
        i_valid = 1'b1;
        i_data  = v;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic run_half(input logic lv, input int drop_at, input int stop_at,
                            input int load_at, input logic [15:0] lval, input int rst_at);
        i_lrc  = lv;
        cap_d0 = '0;
        cap_d1 = '0;
        b0 = 0; b1 = 0; u0 = 0; u1 = 0;
        for (int j = 0; j < 40; j++) begin
            i_stop  = 1'b0;
            i_valid = 1'b0;
            if (j == drop_at) i_en = 1'b0;
            if (j == stop_at) begin
                i_stop  = 1'b1;
                i_valid = 1'b1;
                i_data  = 16'hAAAA;
            end
            if (j == load_at) begin
                i_valid = 1'b1;
                i_data  = lval;
            end
            if (j == rst_at) begin
                i_rst_n = 1'b1;
                #2;
                chk("rst_async_dac", 64'(o_dacdat1), 64'd0);
                chk("rst_async_busy", 64'(o_busy1), 64'd0);
                i_rst_n = 1'b0;
            end
            @(negedge i_clk);
            cap_d0[j] = o_dacdat0;
            cap_d1[j] = o_dacdat1;
            b0 += int'(o_busy0);
            b1 += int'(o_busy1);
            u0 += int'(o_underrun0);
            u1 += int'(o_underrun1);
            @(posedge i_clk); #1;
        end
        i_stop  = 1'b0;
        i_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'hF2CF, 16'hF2CF, 1'b0};
        tbl[1] = '{1'b1, 16'hF64F, 16'hF64F, 1'b0};
        tbl[2] = '{1'b1, 16'h83C1, 16'h83C1, 1'b0};
        tbl[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1};
        tbl[4] = '{1'b1, 16'h9C58, 16'h9C58, 1'b0};

        i_rst_n = 1'b1; i_lrc = 1'b0; i_en = 1'b0; i_stop = 1'b0; i_valid = 1'b0; i_data = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_dac0", 64'(o_dacdat0), 64'd0);
        chk("rst_busy0", 64'(o_busy0), 64'd0);
        chk("rst_ur0", 64'(o_underrun0), 64'd0);
        chk("rst_ready0", 64'(o_ready0), 64'd1);
        chk("rst_ready1", 64'(o_ready1), 64'd1);
        chk("rst_dac1", 64'(o_dacdat1), 64'd0);
        i_rst_n = 1'b0;
        i_en    = 1'b1;

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].load) do_load(tbl[i].smp, 1'b0);
            run_half(1'b1, -1, -1, -1, 16'h0, -1);
            chk($sformatf("v%0d_right_quiet", i), 64'(cap_d0), 64'd0);
            run_half(1'b0, -1, -1, -1, 16'h0, -1);
            chk($sformatf("v%0d_dac", i), 64'(cap_d0), 64'(ev(tbl[i].exp_w, 16)));
            chk($sformatf("v%0d_busy", i), 64'(b0), tbl[i].exp_ur ? 64'd0 : 64'd16);
            chk($sformatf("v%0d_underrun", i), 64'(u0), 64'(tbl[i].exp_ur));
        end

        // enable dropped mid-word, next sample queued while paused
        do_load(16'h6A4C, 1'b0);
        run_half(1'b1, -1, -1, -1, 16'h0, -1);
        run_half(1'b0, 6, -1, 20, 16'h5A3C, -1);
        chk("endrop_dac", 64'(cap_d0), 64'(ev(16'h6A4C, 16)));
        chk("endrop_ready", 64'(o_ready0), 64'd0);
        run_half(1'b1, -1, -1, -1, 16'h0, -1);
        run_half(1'b0, -1, -1, -1, 16'h0, -1);
        chk("paused_dac", 64'(cap_d0), 64'd0);
        chk("paused_ur", 64'(u0), 64'd0);
        chk("paused_ready", 64'(o_ready0), 64'd0);
        i_en = 1'b1;
        run_half(1'b1, -1, -1, -1, 16'h0, -1);
        run_half(1'b0, -1, -1, -1, 16'h0, -1);
        chk("resume_dac", 64'(cap_d0), 64'(ev(16'h5A3C, 16)));

        // stop mid-word with a simultaneous i_valid
        do_load(16'hF64F, 1'b0);
        run_half(1'b1, -1, -1, -1, 16'h0, -1);
        run_half(1'b0, -1, 8, -1, 16'h0, -1);
        chk("stop_dac", 64'(cap_d0), 64'(ev(16'hF64F, 8)));
        chk("stop_busy", 64'(b0), 64'd8);
        chk("stop_ready", 64'(o_ready0), 64'd1);
        run_half(1'b1, -1, -1, -1, 16'h0, -1);
        run_half(1'b0, -1, -1, -1, 16'h0, -1);
        chk("stop_next_dac", 64'(cap_d0), 64'd0);
        chk("stop_next_ur", 64'(u0), 64'd1);

        // right-channel build
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        do_load(16'h83C1, 1'b1);
        run_half(1'b1, -1, -1, -1, 16'h0, -1);
        chk("ch1_dac", 64'(cap_d1), 64'(ev(16'h83C1, 16)));
        chk("ch1_busy", 64'(b1), 64'd16);
        run_half(1'b0, -1, -1, -1, 16'h0, -1);
        chk("ch1_fall_quiet", 64'(cap_d1), 64'd0);
        do_load(16'h83C1, 1'b1);
        run_half(1'b1, -1, -1, -1, 16'h0, 7);
        chk("ch1_rst_dac", 64'(cap_d1), 64'(ev(16'h83C1, 6)));
        chk("ch1_rst_ready", 64'(o_ready1), 64'd1);
        run_half(1'b0, -1, -1, -1, 16'h0, -1);
        chk("ch1_after_rst_quiet", 64'(cap_d1), 64'd0);
        do_load(16'h83C1, 1'b1);
        run_half(1'b1, -1, -1, -1, 16'h0, -1);
        chk("ch1_restart_dac", 64'(cap_d1), 64'(ev(16'h83C1, 16)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aud_player_tx.md
Name: aud_player_tx

Overview:
- I2S-style serial audio transmitter feeding the codec DAC data pin. It is the playback counterpart of the recorder's serial receiver.
- Runs directly on the codec bit clock (BCLK) and tracks the codec LR clock.
- Accepts 16-bit PCM samples from the playback/SRAM-fetch controller over a valid/ready handshake.
- Shifts each sample out MSB-first in the active channel half-frame.

Parameters:
- DATA_W, 16: sample width in bits; bit counter is clog2(DATA_W)+1 bits.
- CHANNEL, 0: active half-frame. 0 = transmit after i_lrc falling edge (left); 1 = transmit after i_lrc rising edge (right).

Ports:
- i_clk  in  1  codec BCLK; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-high reset (asserted = 1); clears all state immediately.
- i_lrc  in  1  codec LR clock, synchronous to i_clk.
- i_en  in  1  play enable; low = pause after current word.
- i_stop  in  1  one-cycle pulse; abort word and flush buffer.
- i_valid  in  1  i_data holds a sample.
- i_data  in  DATA_W  PCM sample, two's complement.
- o_ready  out  1  buffer can accept a sample.
- o_dacdat  out  1  serial data to the DAC, registered.
- o_busy  out  1  a word is currently being shifted.
- o_underrun  out  1  one-cycle pulse: active edge seen with i_en=1 and buffer empty.

Behaviour:
- Reset values: o_dacdat=0, o_busy=0, o_underrun=0, o_ready=1. Also buf_valid=0, shift=0, cnt=0, lrc_q=0, state=IDLE.
- lrc_q <= i_lrc every cycle.
- act_edge = (i_lrc != lrc_q) && (i_lrc == CHANNEL).
- Buffer: one entry.
  - o_ready = !buf_valid (combinational).
  - Accept when i_valid && o_ready; buf <= i_data, buf_valid <= 1.
  - A sample is never accepted in the same cycle the buffer is drained.
- States: IDLE, WAIT, SEND.
  - IDLE: o_dacdat=0. Go to WAIT when i_en=1.
  - WAIT: on act_edge:
    - If buf_valid: shift <= buf, buf_valid <= 0, emit MSB (see timing), go to SEND.
    - If buffer empty: o_underrun=1 for that cycle, o_dacdat stays 0, remain in WAIT. A zero word is effectively sent.
    - If i_en=0 while in WAIT: go to IDLE.
  - SEND: o_busy=1. Emit one bit per cycle.
    - After the LSB: go to WAIT if i_en=1, else IDLE.
- Timing, with act_edge detected at posedge k:
  - Bit 15 (MSB) drives o_dacdat from posedge k; bits 14..0 from posedges k+1..k+15.
  - At posedge k+16, o_dacdat <= 0 and o_busy <= 0.
  - This gives one-BCLK MSB delay relative to the LRC transition, per I2S.
- Half-frame shorter than DATA_W cycles: truncate. An act_edge while in SEND is ignored; the word continues. Integration guarantees a half-frame of at least 16 BCLK.
- i_en falling mid-word: the word completes unchanged, then IDLE. The buffered sample is retained for resume.
- i_stop (highest priority after reset): next posedge sets state=IDLE, buf_valid=0, cnt=0, o_dacdat=0, o_busy=0.
  - i_valid in the same cycle as i_stop is not accepted.
- i_stop with i_en still 1: IDLE for one cycle, then WAIT. Playback restarts on the next act_edge (underrun if no sample).
- Reset asserted mid-word: outputs return to reset values asynchronously. After release, wait for a fresh act_edge.
- Only act_edge starts a word. lrc_q comes out of reset at 0, so with CHANNEL=0 a low i_lrc at release does not start a word.

Test Plan:
- BCLK 10 ns, LRC period 800 ns, CHANNEL=0, preload 0xF2CF, i_en=1 -> after LRC fall, o_dacdat = 1111_0010_1100_1111 over 16 cycles MSB-first, then 0 for the remaining 24 cycles; o_busy high exactly 16 cycles.
- Back-to-back: present 0xF64F then 0x83C1, refilled as o_ready rises -> consecutive left half-frames carry both words exactly; no o_underrun.
- Empty buffer at LRC fall with i_en=1 -> o_underrun pulses once, o_dacdat=0 whole frame. Sample 0x9C58 supplied later goes out on the following LRC fall.
- i_en dropped at bit 5 of 0x6A4C -> all 16 bits still sent correctly, then IDLE. Sample queued in buffer stays (o_ready=0). Re-enable -> queued sample goes out on the next LRC fall.
- i_stop pulsed at bit 8 of 0xF64F with i_valid=1 -> o_dacdat=0 and o_busy=0 the next cycle; o_ready=1; the i_valid sample is not captured.
- CHANNEL=1 build, 0x83C1 -> shifting starts one cycle after LRC rise; LRC fall does nothing. Async reset pulse mid-word -> o_dacdat=0 immediately, no output until the next LRC rise with a loaded sample.
